// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-subset pipeline.
// Holds opcode/funct constants, the ALU operation encoding and the control
// bundle that travels from decode into EX.
// No ports (package).
package mips_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_e;

    typedef struct packed {
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    alu_src;
        logic    branch;
        alu_op_e alu_op;
    } ctrl_t;

    // All-zero control: used for NOPs and pipeline bubbles.
    localparam ctrl_t CTRL_NOP = ctrl_t'(8'h00);

endpackage

// File: rtl/id_ex_stage_if.sv
// EX-side bundle produced by the ID/EX pipeline register.
// Handshake: ex_valid alone qualifies every other field in the same cycle;
// there is no ready/backpressure on this boundary (upstream stalls are
// raised through the stage's stall output instead). Consumers must ignore
// all fields while ex_valid is 0.
// Modports:
//   master - the ID/EX stage, drives every signal
//   slave  - the EX stage, samples every signal
interface id_ex_stage_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  ex_valid;
    logic [DATA_W-1:0]     ex_opA;
    logic [DATA_W-1:0]     ex_opB;
    logic [DATA_W-1:0]     ex_imm;
    logic [REG_ADDR_W-1:0] ex_rs;
    logic [REG_ADDR_W-1:0] ex_rt;
    logic [REG_ADDR_W-1:0] ex_dest;
    logic                  ex_regWrite;
    logic                  ex_memRead;
    logic                  ex_memWrite;
    logic                  ex_aluSrc;
    logic                  ex_branch;
    logic [2:0]            ex_aluOp;

    modport master (
        output ex_valid, ex_opA, ex_opB, ex_imm, ex_rs, ex_rt, ex_dest,
               ex_regWrite, ex_memRead, ex_memWrite, ex_aluSrc, ex_branch,
               ex_aluOp
    );

    modport slave (
        input ex_valid, ex_opA, ex_opB, ex_imm, ex_rs, ex_rt, ex_dest,
              ex_regWrite, ex_memRead, ex_memWrite, ex_aluSrc, ex_branch,
              ex_aluOp
    );
endinterface

// File: rtl/id_decoder.sv
// Combinational instruction decoder.
// Ports:
//   opcode  in  6  instr[31:26]
//   funct   in  6  instr[5:0]
//   rt      in  5  instr[20:16]
//   rd      in  5  instr[15:11]
//   ctrl    out    control bundle (all zero for unsupported encodings)
//   rt_used out 1  rt is a source operand
//   dest    out 5  destination register (0 when nothing is written)
module id_decoder
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic [4:0] rt,
    input  logic [4:0] rd,
    output ctrl_t      ctrl,
    output logic       rt_used,
    output logic [4:0] dest
);

    logic    r_ok;
    alu_op_e r_alu;

    // R-type funct lookup; an unknown funct makes the whole instruction a NOP.
    always_comb begin
        r_ok  = 1'b1;
        r_alu = ALU_ADD;
        case (funct)
            F_ADD:   r_alu = ALU_ADD;
            F_SUB:   r_alu = ALU_SUB;
            F_AND:   r_alu = ALU_AND;
            F_OR:    r_alu = ALU_OR;
            F_SLT:   r_alu = ALU_SLT;
            default: r_ok  = 1'b0;
        endcase
    end

    always_comb begin
        ctrl    = CTRL_NOP;
        rt_used = 1'b0;
        dest    = '0;
        case (opcode)
            OP_RTYPE: begin
                if (r_ok) begin
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_op    = r_alu;
                    rt_used        = 1'b1;
                    dest           = rd;
                end
            end
            OP_ADDI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_ADD;
                dest           = rt;
            end
            OP_LW: begin
                ctrl.reg_write = 1'b1;
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_ADD;
                dest           = rt;
            end
            OP_SW: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_ADD;
                rt_used        = 1'b1;
            end
            OP_BEQ: begin
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALU_SUB;
                rt_used     = 1'b1;
            end
            default: begin
                ctrl = CTRL_NOP;
            end
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// Decode stage plus ID/EX pipeline register.
// Drives register-file read addresses from the IF/ID instruction, decodes
// control, bypasses same-cycle WB writes into the operands, detects load-use
// hazards (stall + bubble) and squashes on branch flush.
// Ports:
//   clk, init                 clock, synchronous active-high reset
//   id_valid, id_instr        IF/ID contents
//   readReg1/2, readData1/2   register-file read port
//   wb_writeEnable/Reg/Data   WB stage write, used for bypass
//   flush                     branch taken in EX
//   stall                     hold PC and IF/ID (combinational)
//   ex                        EX-side bundle (id_ex_stage_if.master)
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  init,
    input  logic                  id_valid,
    input  logic [31:0]           id_instr,
    output logic [REG_ADDR_W-1:0] readReg1,
    output logic [REG_ADDR_W-1:0] readReg2,
    input  logic [DATA_W-1:0]     readData1,
    input  logic [DATA_W-1:0]     readData2,
    input  logic                  wb_writeEnable,
    input  logic [REG_ADDR_W-1:0] wb_writeReg,
    input  logic [DATA_W-1:0]     wb_writeData,
    input  logic                  flush,
    output logic                  stall,
    id_ex_stage_if.master         ex
);

    logic [REG_ADDR_W-1:0] rs, rt, rd, dec_dest;
    logic [DATA_W-1:0]     op_a, op_b, imm;
    ctrl_t                 dec_ctrl;
    logic                  dec_rt_used;
    logic                  hazard;
    logic                  unused_shamt;

    logic                  r_valid;
    logic [DATA_W-1:0]     r_op_a, r_op_b, r_imm;
    logic [REG_ADDR_W-1:0] r_rs, r_rt, r_dest;
    ctrl_t                 r_ctrl;

    assign rs       = id_instr[25:21];
    assign rt       = id_instr[20:16];
    assign rd       = id_instr[15:11];
    assign readReg1 = rs;
    assign readReg2 = rt;
    assign unused_shamt = ^id_instr[10:6];

    id_decoder u_dec (
        .opcode  (id_instr[31:26]),
        .funct   (id_instr[5:0]),
        .rt      (rt),
        .rd      (rd),
        .ctrl    (dec_ctrl),
        .rt_used (dec_rt_used),
        .dest    (dec_dest)
    );

    assign imm = {{(DATA_W-16){id_instr[15]}}, id_instr[15:0]};

    // The register file is read before WB's write lands, so take WB's value
    // when it targets the same register. $0 is hardwired and never bypassed.
    always_comb begin
        op_a = readData1;
        op_b = readData2;
        if (wb_writeEnable && (wb_writeReg != '0) && (wb_writeReg == rs))
            op_a = wb_writeData;
        if (wb_writeEnable && (wb_writeReg != '0) && (wb_writeReg == rt))
            op_b = wb_writeData;
    end

    // Load in EX whose result is needed by the instruction in ID.
    assign hazard = id_valid && r_valid && r_ctrl.mem_read && (r_dest != '0) &&
                    ((r_dest == rs) || (dec_rt_used && (r_dest == rt)));

    // A flush discards the dependent instruction anyway, so no stall then.
    assign stall = hazard && !flush && !init;

    // Reset, flush and hazard all leave the same all-zero bubble in EX.
    always_ff @(posedge clk) begin
        if (init || flush || hazard) begin
            r_valid <= 1'b0;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_imm   <= '0;
            r_rs    <= '0;
            r_rt    <= '0;
            r_dest  <= '0;
            r_ctrl  <= CTRL_NOP;
        end else begin
            r_valid <= id_valid;
            r_op_a  <= op_a;
            r_op_b  <= op_b;
            r_imm   <= imm;
            r_rs    <= rs;
            r_rt    <= rt;
            r_dest  <= dec_dest;
            r_ctrl  <= dec_ctrl;
        end
    end

    assign ex.ex_valid    = r_valid;
    assign ex.ex_opA      = r_op_a;
    assign ex.ex_opB      = r_op_b;
    assign ex.ex_imm      = r_imm;
    assign ex.ex_rs       = r_rs;
    assign ex.ex_rt       = r_rt;
    assign ex.ex_dest     = r_dest;
    assign ex.ex_regWrite = r_ctrl.reg_write;
    assign ex.ex_memRead  = r_ctrl.mem_read;
    assign ex.ex_memWrite = r_ctrl.mem_write;
    assign ex.ex_aluSrc   = r_ctrl.alu_src;
    assign ex.ex_branch   = r_ctrl.branch;
    assign ex.ex_aluOp    = r_ctrl.alu_op;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage.
module tb_id_ex_stage;

    logic        clk;
    logic        init;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [4:0]  readReg1, readReg2;
    logic [31:0] readData1, readData2;
    logic        wb_writeEnable;
    logic [4:0]  wb_writeReg;
    logic [31:0] wb_writeData;
    logic        flush;
    logic        stall;

    int checks;
    int errors;

    id_ex_stage_if #(.DATA_W(32), .REG_ADDR_W(5)) ex_if ();

    id_ex_stage dut (
        .clk            (clk),
        .init           (init),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .readReg1       (readReg1),
        .readReg2       (readReg2),
        .readData1      (readData1),
        .readData2      (readData2),
        .wb_writeEnable (wb_writeEnable),
        .wb_writeReg    (wb_writeReg),
        .wb_writeData   (wb_writeData),
        .flush          (flush),
        .stall          (stall),
        .ex             (ex_if)
    );

    // {regWrite, memRead, memWrite, aluSrc, branch, aluOp[2:0]}
    logic [7:0] ctl;
    assign ctl = {ex_if.ex_regWrite, ex_if.ex_memRead, ex_if.ex_memWrite,
                  ex_if.ex_aluSrc, ex_if.ex_branch, ex_if.ex_aluOp};

    localparam logic [7:0] C_ADD  = 8'h80;
    localparam logic [7:0] C_SUB  = 8'h81;
    localparam logic [7:0] C_AND  = 8'h82;
    localparam logic [7:0] C_OR   = 8'h83;
    localparam logic [7:0] C_SLT  = 8'h84;
    localparam logic [7:0] C_LW   = 8'hD0;
    localparam logic [7:0] C_SW   = 8'h30;
    localparam logic [7:0] C_BEQ  = 8'h09;
    localparam logic [7:0] C_ADDI = 8'h90;

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] f);
        return {6'h00, rs, rt, rd, 5'd0, f};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] im);
        return {op, rs, rt, im};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr,
                         input logic [31:0] d1, input logic [31:0] d2);
        id_valid  = v;
        id_instr  = instr;
        readData1 = d1;
        readData2 = d2;
    endtask

    task automatic test_reset();
        init = 1'b1;
        drive(1'b1, itype(6'h23, 5'd1, 5'd5, 16'd8), 32'd11, 32'd22);
        step();
        step();
        init = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        #1;
        checks++;
        if ({ex_if.ex_valid, ex_if.ex_opA, ex_if.ex_opB, ex_if.ex_imm, ex_if.ex_rs,
             ex_if.ex_rt, ex_if.ex_dest, ctl} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%0b opA=%h opB=%h imm=%h ctl=%h required all zero",
                     ex_if.ex_valid, ex_if.ex_opA, ex_if.ex_opB, ex_if.ex_imm, ctl);
        end
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall: got %0b required 0", stall);
        end
    endtask

    task automatic test_add();
        drive(1'b1, rtype(5'd1, 5'd2, 5'd3, 6'h20), 32'd5, 32'd7);
        #1;
        checks++;
        if ({readReg1, readReg2} !== {5'd1, 5'd2}) begin
            errors++;
            $display("FAIL add_readregs: got %0d,%0d required 1,2", readReg1, readReg2);
        end
        step();
        checks++;
        if ({ex_if.ex_valid, ex_if.ex_opA, ex_if.ex_opB, ex_if.ex_rs, ex_if.ex_rt,
             ex_if.ex_dest, ctl} !== {1'b1, 32'd5, 32'd7, 5'd1, 5'd2, 5'd3, C_ADD}) begin
            errors++;
            $display("FAIL add_latch: valid=%0b opA=%0d opB=%0d rs=%0d rt=%0d dest=%0d ctl=%h required 1 5 7 1 2 3 %h",
                     ex_if.ex_valid, ex_if.ex_opA, ex_if.ex_opB, ex_if.ex_rs, ex_if.ex_rt,
                     ex_if.ex_dest, ctl, C_ADD);
        end
    endtask

    task automatic test_bypass();
        wb_writeEnable = 1'b1;
        wb_writeReg    = 5'd1;
        wb_writeData   = 32'h1234;
        drive(1'b1, rtype(5'd1, 5'd2, 5'd4, 6'h22), 32'd0, 32'd9);
        step();
        checks++;
        if ({ex_if.ex_opA, ex_if.ex_opB, ex_if.ex_dest, ctl} !== {32'h1234, 32'd9, 5'd4, C_SUB}) begin
            errors++;
            $display("FAIL bypass_rs: opA=%h opB=%h dest=%0d ctl=%h required 1234 9 4 %h",
                     ex_if.ex_opA, ex_if.ex_opB, ex_if.ex_dest, ctl, C_SUB);
        end
        // $0 matches wb_writeReg=0 but must not be bypassed
        wb_writeReg  = 5'd0;
        wb_writeData = 32'hDEAD;
        drive(1'b1, rtype(5'd0, 5'd2, 5'd4, 6'h22), 32'h55, 32'd9);
        step();
        checks++;
        if (ex_if.ex_opA !== 32'h55) begin
            errors++;
            $display("FAIL bypass_r0: opA=%h required 55", ex_if.ex_opA);
        end
        // rt side
        wb_writeReg  = 5'd9;
        wb_writeData = 32'hABC;
        drive(1'b1, rtype(5'd2, 5'd9, 5'd7, 6'h20), 32'd3, 32'd4);
        step();
        checks++;
        if ({ex_if.ex_opA, ex_if.ex_opB} !== {32'd3, 32'hABC}) begin
            errors++;
            $display("FAIL bypass_rt: opA=%h opB=%h required 3 abc", ex_if.ex_opA, ex_if.ex_opB);
        end
        wb_writeEnable = 1'b0;
        // write enable low: no bypass even on match
        drive(1'b1, rtype(5'd2, 5'd9, 5'd7, 6'h20), 32'd3, 32'd4);
        step();
        checks++;
        if (ex_if.ex_opB !== 32'd4) begin
            errors++;
            $display("FAIL bypass_we_low: opB=%h required 4", ex_if.ex_opB);
        end
    endtask

    task automatic test_load_use();
        drive(1'b1, itype(6'h23, 5'd1, 5'd5, 16'd8), 32'd100, 32'd0);
        step();
        checks++;
        if ({ex_if.ex_valid, ex_if.ex_dest, ex_if.ex_imm, ctl} !== {1'b1, 5'd5, 32'd8, C_LW}) begin
            errors++;
            $display("FAIL lw_latch: valid=%0b dest=%0d imm=%h ctl=%h required 1 5 8 %h",
                     ex_if.ex_valid, ex_if.ex_dest, ex_if.ex_imm, ctl, C_LW);
        end
        drive(1'b1, rtype(5'd5, 5'd2, 5'd6, 6'h20), 32'd1, 32'd2);
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL load_use_stall: got %0b required 1", stall);
        end
        step();
        checks++;
        if ({ex_if.ex_valid, ctl, stall} !== {1'b0, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL load_use_bubble: valid=%0b ctl=%h stall=%0b required 0 00 0",
                     ex_if.ex_valid, ctl, stall);
        end
        step();
        checks++;
        if ({ex_if.ex_valid, ex_if.ex_rs, ex_if.ex_dest, ctl} !== {1'b1, 5'd5, 5'd6, C_ADD}) begin
            errors++;
            $display("FAIL load_use_resume: valid=%0b rs=%0d dest=%0d ctl=%h required 1 5 6 %h",
                     ex_if.ex_valid, ex_if.ex_rs, ex_if.ex_dest, ctl, C_ADD);
        end
    endtask

    task automatic test_rt_use();
        drive(1'b1, itype(6'h23, 5'd1, 5'd5, 16'd0), 32'd0, 32'd0);
        step();
        drive(1'b1, itype(6'h08, 5'd0, 5'd6, 16'd5), 32'd0, 32'd0);
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL addi_no_stall: got %0b required 0", stall);
        end
        step();
        checks++;
        if ({ex_if.ex_valid, ex_if.ex_dest, ex_if.ex_imm, ctl} !== {1'b1, 5'd6, 32'd5, C_ADDI}) begin
            errors++;
            $display("FAIL addi_latch: valid=%0b dest=%0d imm=%h ctl=%h required 1 6 5 %h",
                     ex_if.ex_valid, ex_if.ex_dest, ex_if.ex_imm, ctl, C_ADDI);
        end
        // negative offset sign-extends
        drive(1'b1, itype(6'h23, 5'd2, 5'd5, 16'hFFF8), 32'd0, 32'd0);
        step();
        checks++;
        if (ex_if.ex_imm !== 32'hFFFF_FFF8) begin
            errors++;
            $display("FAIL imm_sign: got %h required fffffff8", ex_if.ex_imm);
        end
        drive(1'b1, itype(6'h2B, 5'd2, 5'd5, 16'd0), 32'd0, 32'd0);
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL sw_rt_stall: got %0b required 1", stall);
        end
        step();
        checks++;
        if (ex_if.ex_valid !== 1'b0) begin
            errors++;
            $display("FAIL sw_bubble: valid=%0b required 0", ex_if.ex_valid);
        end
        step();
        checks++;
        if ({ex_if.ex_valid, ex_if.ex_dest, ctl} !== {1'b1, 5'd0, C_SW}) begin
            errors++;
            $display("FAIL sw_latch: valid=%0b dest=%0d ctl=%h required 1 0 %h",
                     ex_if.ex_valid, ex_if.ex_dest, ctl, C_SW);
        end
        // load into $0 never creates a hazard
        drive(1'b1, itype(6'h23, 5'd1, 5'd0, 16'd0), 32'd0, 32'd0);
        step();
        drive(1'b1, rtype(5'd0, 5'd0, 5'd6, 6'h20), 32'd0, 32'd0);
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL r0_no_hazard: got %0b required 0", stall);
        end
        step();
    endtask

    task automatic test_flush();
        drive(1'b1, itype(6'h23, 5'd1, 5'd5, 16'd0), 32'd0, 32'd0);
        step();
        drive(1'b1, rtype(5'd5, 5'd2, 5'd6, 6'h20), 32'd1, 32'd2);
        flush = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_stall: got %0b required 0", stall);
        end
        step();
        flush = 1'b0;
        checks++;
        if ({ex_if.ex_valid, ctl, ex_if.ex_opA} !== {1'b0, 8'h00, 32'd0}) begin
            errors++;
            $display("FAIL flush_bubble: valid=%0b ctl=%h opA=%h required 0 00 0",
                     ex_if.ex_valid, ctl, ex_if.ex_opA);
        end
    endtask

    task automatic test_nop();
        drive(1'b1, {6'h3F, 26'h3FF_FFFF}, 32'd1, 32'd2);
        step();
        checks++;
        if ({ex_if.ex_valid, ctl, ex_if.ex_dest} !== {1'b1, 8'h00, 5'd0}) begin
            errors++;
            $display("FAIL nop_opcode: valid=%0b ctl=%h dest=%0d required 1 00 0",
                     ex_if.ex_valid, ctl, ex_if.ex_dest);
        end
        drive(1'b1, rtype(5'd1, 5'd2, 5'd3, 6'h21), 32'd1, 32'd2);
        step();
        checks++;
        if ({ex_if.ex_valid, ctl, ex_if.ex_dest} !== {1'b1, 8'h00, 5'd0}) begin
            errors++;
            $display("FAIL nop_funct: valid=%0b ctl=%h dest=%0d required 1 00 0",
                     ex_if.ex_valid, ctl, ex_if.ex_dest);
        end
        drive(1'b1, itype(6'h04, 5'd1, 5'd2, 16'hFFFF), 32'd0, 32'd0);
        step();
        checks++;
        if ({ex_if.ex_valid, ctl, ex_if.ex_dest, ex_if.ex_imm} !== {1'b1, C_BEQ, 5'd0, 32'hFFFF_FFFF}) begin
            errors++;
            $display("FAIL beq_latch: valid=%0b ctl=%h dest=%0d imm=%h required 1 %h 0 ffffffff",
                     ex_if.ex_valid, ctl, ex_if.ex_dest, ex_if.ex_imm, C_BEQ);
        end
        drive(1'b0, rtype(5'd1, 5'd2, 5'd3, 6'h20), 32'd0, 32'd0);
        step();
        checks++;
        if (ex_if.ex_valid !== 1'b0) begin
            errors++;
            $display("FAIL invalid_id: valid=%0b required 0", ex_if.ex_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] fn [4];
        logic [7:0] ex_ctl [4];
        fn[0] = 6'h20; ex_ctl[0] = C_ADD;
        fn[1] = 6'h22; ex_ctl[1] = C_SUB;
        fn[2] = 6'h24; ex_ctl[2] = C_AND;
        fn[3] = 6'h25; ex_ctl[3] = C_OR;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, rtype(5'(i + 1), 5'(i + 2), 5'(i + 10), fn[i]), 32'(i * 3), 32'(i * 7));
            step();
            checks++;
            if ({ex_if.ex_valid, ex_if.ex_opA, ex_if.ex_opB, ex_if.ex_dest, ctl} !==
                {1'b1, 32'(i * 3), 32'(i * 7), 5'(i + 10), ex_ctl[i]}) begin
                errors++;
                $display("FAIL b2b_%0d: opA=%0d opB=%0d dest=%0d ctl=%h required %0d %0d %0d %h",
                         i, ex_if.ex_opA, ex_if.ex_opB, ex_if.ex_dest, ctl,
                         i * 3, i * 7, i + 10, ex_ctl[i]);
            end
        end
        drive(1'b1, rtype(5'd3, 5'd4, 5'd8, 6'h2A), 32'd0, 32'd0);
        step();
        checks++;
        if (ctl !== C_SLT) begin
            errors++;
            $display("FAIL slt_ctl: got %h required %h", ctl, C_SLT);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, itype(6'h23, 5'd1, 5'd5, 16'd4), 32'd0, 32'd0);
        step();
        drive(1'b1, rtype(5'd5, 5'd2, 5'd6, 6'h20), 32'd1, 32'd2);
        init = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_stall: got %0b required 0", stall);
        end
        step();
        init = 1'b0;
        checks++;
        if ({ex_if.ex_valid, ex_if.ex_opA, ex_if.ex_imm, ex_if.ex_dest, ctl} !== '0) begin
            errors++;
            $display("FAIL reset_mid_clear: valid=%0b opA=%h imm=%h dest=%0d ctl=%h required all zero",
                     ex_if.ex_valid, ex_if.ex_opA, ex_if.ex_imm, ex_if.ex_dest, ctl);
        end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        init           = 1'b1;
        flush          = 1'b0;
        wb_writeEnable = 1'b0;
        wb_writeReg    = 5'd0;
        wb_writeData   = 32'd0;
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        #1;
        test_reset();
        test_add();
        test_bypass();
        test_load_use();
        test_rt_use();
        test_flush();
        test_nop();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
Decode stage plus ID/EX pipeline register for the MIPS-subset pipeline. It takes the IF/ID instruction, drives the register-file read addresses, and decodes control. It latches operands (with WB-to-ID bypass) and control into the EX stage. It also detects load-use hazards, raising a stall and inserting a bubble, and it squashes the stage on branch flush.

Parameters:
DATA_W, 32, datapath width
REG_ADDR_W, 5, register-file address width

Ports:
clk  in  1  rising-edge clock
init  in  1  synchronous, active-high reset
id_valid  in  1  IF/ID holds a valid instruction
id_instr  in  32  instruction from IF/ID
readReg1  out  5  register-file read address 1 = id_instr[25:21] (rs), combinational
readReg2  out  5  register-file read address 2 = id_instr[20:16] (rt), combinational
readData1  in  DATA_W  register-file data for readReg1
readData2  in  DATA_W  register-file data for readReg2
wb_writeEnable  in  1  WB stage writing the register file this cycle
wb_writeReg  in  5  WB destination
wb_writeData  in  DATA_W  WB data
flush  in  1  branch taken in EX; squash the ID instruction
stall  out  1  hold PC and IF/ID, combinational
ex_valid  out  1  EX slot holds a real instruction
ex_opA, ex_opB  out  DATA_W  latched rs/rt operands
ex_imm  out  DATA_W  sign-extended imm[15:0]
ex_rs, ex_rt, ex_dest  out  5  source and destination register numbers
ex_regWrite, ex_memRead, ex_memWrite, ex_aluSrc, ex_branch  out  1 each  control bits
ex_aluOp  out  3  ALU operation code

Behaviour:
- Supported instructions:
  - R-type (op 0x00; funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A)
  - addi 0x08, lw 0x23, sw 0x2B, beq 0x04
  - Any other opcode or funct decodes as a NOP: all control bits 0, but ex_valid still follows id_valid.
- ex_dest:
  - R-type: rd.
  - addi/lw: rt.
  - sw/beq: 0, with regWrite=0.
- Sources used: rs is used by all supported instructions. rt is a source only for R-type, sw and beq.
- Bypass: if wb_writeEnable and wb_writeReg!=0 and wb_writeReg==rs, ex_opA latches wb_writeData; otherwise readData1. ex_opB follows the same rule with rt/readData2.
- hazard = id_valid & ex_valid & ex_memRead & ex_dest!=0 & (ex_dest==rs | (rtUsed & ex_dest==rt)).
- stall = hazard & ~flush & ~init, combinational, same cycle.
- Register update at posedge, in priority order:
  1. init: all ex_* outputs become 0.
  2. flush: bubble.
  3. hazard: bubble.
  4. Otherwise: latch the decoded instruction, ex_valid=id_valid.
- Bubble definition: ex_valid=0 and all control bits 0. Data fields are don't-care but are driven 0.
- Latency: one cycle from ID to EX outputs. A load-use pair costs exactly one bubble, because the next cycle's ex_memRead belongs to the bubble.
- Reset mid-operation: outputs clear on the next edge and stall drops to 0 immediately. The instruction in ID is lost; upstream reset owns refetch.
- Register 0: never bypassed and never a hazard source.
- flush and hazard in the same cycle: flush wins, stall=0.

Decomposition:
- Shared package mips_pkg holds:
  - opcode and funct constants
  - ALU op encoding: ADD=0, SUB=1, AND=2, OR=3, SLT=4
  - a control-bundle struct (regWrite, memRead, memWrite, aluSrc, branch, aluOp)
- One combinational sub-module, id_decoder: opcode/funct → control bundle, rtUsed, dest select.
- Hazard detection, bypass and the pipeline register stay in id_ex_stage.

Test Plan:
1. Hold init=1 for 2 cycles, then release → all ex_* = 0 and stall=0.
2. add $3,$1,$2 with readData1=5, readData2=7 → next cycle: ex_valid=1, ex_opA=5, ex_opB=7, ex_dest=3, ex_aluOp=ADD, ex_regWrite=1.
3. WB writes $1=0x1234 while ID holds sub $4,$1,$2 with readData1=0 → ex_opA=0x1234. Repeat with wb_writeReg=0 → ex_opA=readData1.
4. lw $5,8($1), then add $6,$5,$2 → stall=1 for exactly one cycle and a bubble appears (ex_valid=0). Then add latches with ex_rs=5.
5. lw $5 followed by addi $6,$0,5 → no stall. lw $5 followed by sw $5,0($2) → stall, because rt is used.
6. flush=1 coincident with a load-use hazard → stall=0 and a bubble is latched. Opcode 0x3F → ex_valid=1 with all control bits 0.
